// File: rtl/muldiv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_pkg
// Shared definitions for the divide sequencing controller:
//   - md_state_t        : controller state encoding (IDLE/BUSY/DONE)
//   - DIV_START/DIV_STOP: level values driven on the divider start line
//   - MAX_CYCLES_DEFAULT: default watchdog limit on BUSY cycles
//   - DIV_ZERO_LO_BIT   : fill bit for the quotient of a divide by zero
//   - wd_count_width()  : counter width needed to hold a watchdog limit
// -----------------------------------------------------------------------------
package muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

    localparam int MAX_CYCLES_DEFAULT = 40;

    // Divide by zero returns the dividend as remainder and an all-ones quotient.
    localparam logic DIV_ZERO_LO_BIT = 1'b1;

    function automatic int wd_count_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_watchdog.sv
// -----------------------------------------------------------------------------
// md_watchdog
// Counts enabled cycles and flags the cycle in which the LIMIT-th enabled cycle
// occurs. The flag is combinational so the owner can act in that same cycle.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clear    : force the count back to zero (takes priority over enable)
//   enable   : count this cycle
//   expired  : high during the LIMIT-th consecutive enabled cycle
// -----------------------------------------------------------------------------
module md_watchdog
    import muldiv_ctrl_pkg::*;
#(
    parameter int LIMIT = MAX_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = wd_count_width(LIMIT);
    // Count value seen during the LIMIT-th enabled cycle (count starts at 0).
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LAST)) begin
            // Saturate at LAST; the owner leaves the counted state on expiry.
            count_reg <= count_reg + CW'(1);
        end
    end

    assign expired = enable && (count_reg == LAST);

endmodule

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// Sequences one DIV/DIVU instruction from the EX stage through an external
// iterative divider. Operands are latched once on acceptance, div_start is held
// as a level for the whole operation, the front of the pipe is stalled while the
// divide runs, and the {hi,lo} result is presented for exactly one commit.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   op_valid/op_signed: EX holds a DIV (signed) or DIVU instruction
//   a, b              : dividend / divisor from EX
//   flush             : EX instruction is being killed
//   ex_hold           : EX cannot advance this cycle
//   stall             : freeze IF..EX
//   res_valid, hi, lo : result for the current EX instruction (0 when invalid)
//   timeout_err       : one-cycle pulse when the watchdog abandons an operation
//   div_start/annul/signed/a/b : divider request side
//   div_result, div_ready      : divider response side ({remainder, quotient})
// -----------------------------------------------------------------------------
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MAX_CYCLES = MAX_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    input  logic               op_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               flush,
    input  logic               ex_hold,
    output logic               stall,
    output logic               res_valid,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               timeout_err,
    output logic               div_start,
    output logic               div_annul,
    output logic               div_signed,
    output logic [WIDTH-1:0]   div_a,
    output logic [WIDTH-1:0]   div_b,
    input  logic [2*WIDTH-1:0] div_result,
    input  logic               div_ready
);

    md_state_t          state_reg;
    logic               div_start_reg;
    logic               div_signed_reg;
    logic [WIDTH-1:0]   div_a_reg;
    logic [WIDTH-1:0]   div_b_reg;
    logic [2*WIDTH-1:0] result_reg;

    logic accept;
    logic wd_expired;
    logic wd_fire;

    // A new instruction is taken only from IDLE, and never one being flushed.
    assign accept = (state_reg == IDLE) && op_valid && !flush;

    md_watchdog #(
        .LIMIT (MAX_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_reg != BUSY),
        .enable  (state_reg == BUSY),
        .expired (wd_expired)
    );

    // The divider answering in the last allowed cycle still counts as success.
    // A flush in that cycle wins and kills the operation without an error.
    assign wd_fire = wd_expired && !div_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset abandons any divide in flight: no annul, no result.
            state_reg      <= IDLE;
            div_start_reg  <= DIV_STOP;
            div_signed_reg <= 1'b0;
            div_a_reg      <= '0;
            div_b_reg      <= '0;
            result_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (b != '0) begin
                            div_a_reg      <= a;
                            div_b_reg      <= b;
                            div_signed_reg <= op_signed;
                            div_start_reg  <= DIV_START;
                            state_reg      <= BUSY;
                        end else begin
                            // Divide by zero never touches the divider.
                            result_reg <= {a, {WIDTH{DIV_ZERO_LO_BIT}}};
                            state_reg  <= DONE;
                        end
                    end
                end

                BUSY: begin
                    if (flush) begin
                        div_start_reg <= DIV_STOP;
                        state_reg     <= IDLE;
                    end else if (div_ready) begin
                        result_reg    <= div_result;
                        div_start_reg <= DIV_STOP;
                        state_reg     <= DONE;
                    end else if (wd_fire) begin
                        // Hung divider: hand back zero so the pipe can drain.
                        result_reg    <= '0;
                        div_start_reg <= DIV_STOP;
                        state_reg     <= DONE;
                    end
                end

                DONE: begin
                    // Held result stays put; op_valid is ignored until commit.
                    if (flush || !ex_hold) begin
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    div_start_reg <= DIV_STOP;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign div_start  = div_start_reg;
    assign div_signed = div_signed_reg;
    assign div_a      = div_a_reg;
    assign div_b      = div_b_reg;

    // Stall and result visibility must react within the cycle, so these are
    // decoded from the current state plus the live EX-side controls.
    always_comb begin
        stall       = 1'b0;
        res_valid   = 1'b0;
        div_annul   = 1'b0;
        timeout_err = 1'b0;
        hi          = '0;
        lo          = '0;
        case (state_reg)
            IDLE: begin
                stall = accept;
            end
            BUSY: begin
                stall       = 1'b1;
                div_annul   = flush || wd_fire;
                timeout_err = wd_fire;
            end
            DONE: begin
                res_valid = !flush;
                if (!flush) begin
                    hi = result_reg[2*WIDTH-1:WIDTH];
                    lo = result_reg[WIDTH-1:0];
                end
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
// Directed bench for muldiv_ctrl with a latency-programmable divider model and a
// transaction-level reference model checked on every negative clock edge.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;

    localparam int W    = 32;
    localparam int MAXC = 40;

    logic          clk;
    logic          rst;
    logic          op_valid;
    logic          op_signed;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          flush;
    logic          ex_hold;
    logic          stall;
    logic          res_valid;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          timeout_err;
    logic          div_start;
    logic          div_annul;
    logic          div_signed;
    logic [W-1:0]  div_a;
    logic [W-1:0]  div_b;
    logic [2*W-1:0] div_result;
    logic          div_ready;

    int tests = 0;
    int fails = 0;
    int lat   = 36;   // divider answers in the lat-th start cycle; 0 = never
    int dcnt  = 0;

    muldiv_ctrl #(.WIDTH(W), .MAX_CYCLES(MAXC)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_signed  (op_signed),
        .a          (a),
        .b          (b),
        .flush      (flush),
        .ex_hold    (ex_hold),
        .stall      (stall),
        .res_valid  (res_valid),
        .hi         (hi),
        .lo         (lo),
        .timeout_err(timeout_err),
        .div_start  (div_start),
        .div_annul  (div_annul),
        .div_signed (div_signed),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_result (div_result),
        .div_ready  (div_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Plain arithmetic reference: {remainder, quotient}, C-style truncation.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] x,
                                            input logic [31:0] y);
        logic signed [31:0] xs;
        logic signed [31:0] ys;
        logic [31:0] q;
        logic [31:0] r;
        if (y == 32'd0) return 64'd0;
        xs = x;
        ys = y;
        if (s) begin
            q = xs / ys;
            r = xs % ys;
        end else begin
            q = x / y;
            r = x % y;
        end
        return {r, q};
    endfunction

    // Divider model: counts consecutive start cycles.
    always @(posedge clk) dcnt <= div_start ? dcnt + 1 : 0;
    assign div_ready  = div_start && (lat != 0) && (dcnt == lat - 1);
    assign div_result = ref_div(div_signed, div_a, div_b);

    // ---------------- reference model + per-cycle compare ----------------
    localparam int M_IDLE = 0;
    localparam int M_WORK = 1;
    localparam int M_DONE = 2;

    int          m_mode = M_IDLE;
    int          m_k    = 0;
    logic [31:0] m_a    = '0;
    logic [31:0] m_b    = '0;
    logic        m_s    = 1'b0;
    logic [63:0] m_res  = '0;

    always @(negedge clk) begin
        logic e_stall, e_rv, e_start, e_annul, e_tmo, fin, to, ok;
        logic [31:0] e_hi, e_lo;
        int k;
        if (rst) begin
            m_mode = M_IDLE;
            m_k    = 0;
        end else begin
            e_stall = 0; e_rv = 0; e_start = 0; e_annul = 0; e_tmo = 0;
            e_hi = '0; e_lo = '0; fin = 0; to = 0; k = 0;
            case (m_mode)
                M_IDLE: e_stall = op_valid && !flush;
                M_WORK: begin
                    k       = m_k + 1;
                    fin     = (lat != 0) && (k == lat);
                    to      = !fin && (k == MAXC);
                    e_stall = 1;
                    e_start = 1;
                    e_annul = flush || to;
                    e_tmo   = !flush && to;
                end
                default: begin
                    e_rv = !flush;
                    if (e_rv) begin
                        e_hi = m_res[63:32];
                        e_lo = m_res[31:0];
                    end
                end
            endcase
            ok = (stall === e_stall) && (res_valid === e_rv) && (hi === e_hi) &&
                 (lo === e_lo) && (div_start === e_start) &&
                 (div_annul === e_annul) && (timeout_err === e_tmo);
            if (m_mode == M_WORK)
                ok = ok && (div_a === m_a) && (div_b === m_b) && (div_signed === m_s);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL model t=%0t got/exp stall=%b/%b rv=%b/%b hi=%h/%h lo=%h/%h start=%b/%b annul=%b/%b tmo=%b/%b div_a=%h/%h div_b=%h/%h",
                         $time, stall, e_stall, res_valid, e_rv, hi, e_hi, lo, e_lo,
                         div_start, e_start, div_annul, e_annul, timeout_err, e_tmo,
                         div_a, m_a, div_b, m_b);
            end
            case (m_mode)
                M_IDLE: begin
                    if (op_valid && !flush) begin
                        if (b != 0) begin
                            m_mode = M_WORK;
                            m_k    = 0;
                            m_a    = a;
                            m_b    = b;
                            m_s    = op_signed;
                            m_res  = ref_div(op_signed, a, b);
                        end else begin
                            m_mode = M_DONE;
                            m_res  = {a, 32'hFFFF_FFFF};
                        end
                    end
                end
                M_WORK: begin
                    if (flush) m_mode = M_IDLE;
                    else if (fin) m_mode = M_DONE;
                    else if (to) begin
                        m_mode = M_DONE;
                        m_res  = '0;
                    end else m_k = k;
                end
                default: if (flush || !ex_hold) m_mode = M_IDLE;
            endcase
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y,
                         input int l);
        op_valid  = 1'b1;
        op_signed = s;
        a         = x;
        b         = y;
        lat       = l;
    endtask

    task automatic settle();
        op_valid = 1'b0;
        flush    = 1'b0;
        ex_hold  = 1'b0;
        tick();
        tick();
    endtask

    // Waits (bounded) for res_valid, counting stall and start cycles before it.
    task automatic wait_rv(input string name, input int bound, output int stalls,
                           output int starts);
        logic found;
        found  = 1'b0;
        stalls = 0;
        starts = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (res_valid) begin
                found = 1'b1;
                break;
            end
            stalls += int'(stall);
            starts += int'(div_start);
        end
        if (!found) check({name, " res_valid wait expired"}, 64'd0, 64'd1);
    endtask

    initial begin
        #50000;
        $display("FAIL global time limit reached");
        $fatal(1, "simulation time limit");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int st, sr, an, rv, busy;
        logic found;
        rst = 1'b1; op_valid = 0; op_signed = 0; a = '0; b = '0;
        flush = 0; ex_hold = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ctl", {stall, res_valid, timeout_err, div_start, div_annul, div_signed}, 64'd0);
        check("reset hi/lo", {hi, lo}, 64'd0);
        check("reset div_a/b", {div_a, div_b}, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1: signed -7 / 2 with a 36-cycle divider
        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 36);
        wait_rv("div signed", 100, st, sr);
        check("t1 stall cycles", 64'(st), 64'd37);
        check("t1 start cycles", 64'(sr), 64'd36);
        check("t1 lo", 64'(lo), 64'hFFFF_FFFD);
        check("t1 hi", 64'(hi), 64'hFFFF_FFFF);
        check("t1 done stall", 64'(stall), 64'd0);

        // 2: back-to-back DIVU 100/7; EX operands change mid-operation
        tick();
        issue(1'b0, 32'd100, 32'd7, 10);
        @(negedge clk);
        check("t2 accepted after bubble", 64'(stall), 64'd1);
        tick(); tick(); tick();
        a = 32'd999;
        b = 32'd0;
        @(negedge clk);
        check("t2 div_a held", 64'(div_a), 64'd100);
        check("t2 div_b held", 64'(div_b), 64'd7);
        wait_rv("divu", 100, st, sr);
        check("t2 lo", 64'(lo), 64'd14);
        check("t2 hi", 64'(hi), 64'd2);
        tick();
        settle();

        // 3: divide by zero
        issue(1'b1, 32'h1234_5678, 32'd0, 36);
        @(negedge clk);
        check("t3 stall", 64'(stall), 64'd1);
        check("t3 no start idle", 64'(div_start), 64'd0);
        tick();
        op_valid = 1'b0;
        @(negedge clk);
        check("t3 res_valid", 64'(res_valid), 64'd1);
        check("t3 hi", 64'(hi), 64'h1234_5678);
        check("t3 lo", 64'(lo), 64'hFFFF_FFFF);
        check("t3 no start done", 64'(div_start), 64'd0);
        settle();

        // 4: flush at BUSY cycle 10
        issue(1'b0, 32'd1000, 32'd10, 36);
        repeat (10) tick();
        flush = 1'b1;
        an = 0; rv = 0;
        @(negedge clk);
        an += int'(div_annul);
        check("t4 start in flush cycle", 64'(div_start), 64'd1);
        tick();
        flush = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);
        check("t4 idle stall", 64'(stall), 64'd0);
        check("t4 idle start", 64'(div_start), 64'd0);
        an += int'(div_annul);
        rv += int'(res_valid);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            an += int'(div_annul);
            rv += int'(res_valid);
        end
        check("t4 annul pulses", 64'(an), 64'd1);
        check("t4 no result", 64'(rv), 64'd0);
        settle();

        // 5: ex_hold in DONE with op_valid held
        ex_hold = 1'b1;
        issue(1'b0, 32'd50, 32'd3, 5);
        wait_rv("hold", 100, st, sr);
        sr = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("t5 held rv", 64'(res_valid), 64'd1);
            check("t5 held result", {hi, lo}, {32'd2, 32'd16});
            sr += int'(div_start);
        end
        check("t5 no restart", 64'(sr), 64'd0);
        tick();
        ex_hold  = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);
        check("t5 commit cycle rv", 64'(res_valid), 64'd1);
        tick();
        @(negedge clk);
        check("t5 after commit rv", 64'(res_valid), 64'd0);
        settle();

        // 6: hung divider -> watchdog
        issue(1'b1, 32'd77, 32'd5, 0);
        busy = 0; found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            busy += int'(div_start);
            if (timeout_err) begin
                found = 1'b1;
                break;
            end
        end
        check("t6 timeout seen", 64'(found), 64'd1);
        check("t6 busy cycles", 64'(busy), 64'd40);
        check("t6 annul with timeout", 64'(div_annul), 64'd1);
        tick();
        op_valid = 1'b0;
        @(negedge clk);
        check("t6 rv", 64'(res_valid), 64'd1);
        check("t6 zero result", {hi, lo}, 64'd0);
        settle();

        // 7: flush in DONE drops res_valid the same cycle; flush in IDLE blocks issue
        ex_hold = 1'b1;
        issue(1'b0, 32'h0000_CAFE, 32'd0, 36);
        tick();
        op_valid = 1'b0;
        @(negedge clk);
        check("t7 rv before flush", 64'(res_valid), 64'd1);
        tick();
        flush = 1'b1;
        @(negedge clk);
        check("t7 rv masked", 64'(res_valid), 64'd0);
        check("t7 hi/lo masked", {hi, lo}, 64'd0);
        tick();
        flush = 1'b0;
        ex_hold = 1'b0;
        @(negedge clk);
        check("t7 idle after flush", 64'(res_valid), 64'd0);
        issue(1'b0, 32'd9, 32'd3, 4);
        flush = 1'b1;
        @(negedge clk);
        check("t7 flushed op no stall", 64'(stall), 64'd0);
        tick();
        flush = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);
        check("t7 flushed op no start", 64'(div_start), 64'd0);
        settle();

        // 8: reset mid-BUSY
        issue(1'b1, 32'd500, 32'd9, 36);
        repeat (5) tick();
        rst = 1'b1;
        op_valid = 1'b0;
        @(negedge clk);
        check("t8 annul before reset edge", 64'(div_annul), 64'd0);
        tick();
        @(negedge clk);
        check("t8 reset ctl", {stall, res_valid, timeout_err, div_start, div_annul, div_signed}, 64'd0);
        check("t8 reset hi/lo", {hi, lo}, 64'd0);
        check("t8 reset div_a/b", {div_a, div_b}, 64'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
